// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM decoder: FSM state encoding,
// default duty width and the saturating duty truncation.
package pwm_pkg;

   localparam int PWM_DEFAULT_N = 8;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      MEASURE = 2'd1,
      STATIC  = 2'd2
   } pwm_dec_state_t;

   // Clamps a high-sample count to the largest n-bit duty value.
   function automatic logic [31:0] pwm_sat(input logic [31:0] high_cnt, input int n);
      logic [31:0] max_v;
      max_v = (32'd1 << n) - 32'd1;
      return (high_cnt > max_v) ? max_v : high_cnt;
   endfunction

endpackage

// File: rtl/pwm_edge_sampler.sv
// Step-qualified sampler for the PWM line: produces the conditioned sample s
// and rise/fall strobes. Defining PWM_DECODER_SYNC_EN inserts a 2-flop synchronizer.
module pwm_edge_sampler (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic step,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall
);

   logic prev_q;
   logic prev_d;

`ifdef PWM_DECODER_SYNC_EN
   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], pwm_in};
   end

   // Runs every clk regardless of step so an asynchronous line settles before use.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign s = sync_q[1];
`else
   assign s = pwm_in;
`endif

   always_comb begin
      prev_d = prev_q;
      if (clr) begin
         prev_d = 1'b0;
      end else if (step) begin
         prev_d = s;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = step & s & ~prev_q;
   assign fall = step & ~s & prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the N-bit duty value from a step-sampled PWM waveform, flags period
// errors and static lines. PWM_DECODER_SYNC_EN enables the input synchronizer.
module pwm_decoder
   import pwm_pkg::*;
#(
   parameter int N       = PWM_DEFAULT_N,
   parameter int TIMEOUT = 2 ** (N + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         step,
   input  logic         pwm_in,
   output logic [N-1:0] duty,
   output logic         valid,
   output logic         period_err,
   output logic         stuck
);

   localparam int CW = N + 2;
   localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] NOM_PERIOD = CW'(2 ** N);
   localparam logic [CW-1:0] ONE        = CW'(1);

   logic s;
   logic rise;
   logic fall;

   pwm_dec_state_t state_q, state_d;
   logic [CW-1:0]  period_q, period_d;
   logic [CW-1:0]  high_q, high_d;
   logic [N-1:0]   duty_q, duty_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic           stuck_q, stuck_d;
   logic [CW-1:0]  period_inc;

   pwm_edge_sampler u_sampler (
      .clk    (clk),
      .rst    (rst),
      .clr    (~ena),
      .step   (step),
      .pwm_in (pwm_in),
      .s      (s),
      .rise   (rise),
      .fall   (fall)
   );

   always_comb begin
      // NOTE: every signal written here is given a default first, so no path can infer a latch.
      state_d    = state_q;
      period_d   = period_q;
      high_d     = high_q;
      duty_d     = duty_q;
      err_d      = err_q;
      stuck_d    = stuck_q;
      valid_d    = 1'b0;
      period_inc = period_q + ONE;

      if (!ena) begin
         state_d  = ACQUIRE;
         period_d = '0;
         high_d   = '0;
      end else if (step) begin
         unique case (state_q)
            ACQUIRE: begin
               if (rise) begin
                  state_d  = MEASURE;
                  period_d = ONE;
                  high_d   = ONE;
               end else begin
                  period_d = period_inc;
               end
            end
            MEASURE: begin
               if (rise) begin
                  duty_d   = N'(pwm_sat(32'(high_q), N));
                  err_d    = (period_q != NOM_PERIOD);
                  stuck_d  = 1'b0;
                  valid_d  = 1'b1;
                  period_d = ONE;
                  high_d   = ONE;
               end else begin
                  period_d = period_inc;
                  high_d   = high_q + CW'(s);
               end
            end
            STATIC: begin
               // stuck is left set here; only the next publish clears it.
               if (rise) begin
                  state_d  = MEASURE;
                  period_d = ONE;
                  high_d   = ONE;
               end else if (fall) begin
                  state_d  = ACQUIRE;
                  period_d = '0;
                  high_d   = '0;
               end
            end
            default: begin
               state_d  = ACQUIRE;
               period_d = '0;
               high_d   = '0;
            end
         endcase

         // A rise on the timeout sample takes precedence over declaring the line static.
         if ((state_q == ACQUIRE || state_q == MEASURE) && !rise && period_inc == TO_LAST) begin
            state_d = STATIC;
            duty_d  = {N{s}};
            stuck_d = 1'b1;
            err_d   = 1'b0;
            valid_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ACQUIRE;
         period_q <= '0;
         high_q   <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         high_q   <= high_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         stuck_q  <= stuck_d;
      end
   end

   assign duty       = duty_q;
   assign valid      = valid_q;
   assign period_err = err_q;
   assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: a sample-history reference model is
// compared every cycle, plus directed scenarios pinned by literal expectations.
module tb_pwm_decoder;

   localparam int N       = 8;
   localparam int TIMEOUT = 512;
   localparam int FULL    = 256;
`ifdef PWM_DECODER_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         ena;
   logic         step;
   logic         pwm_in;
   logic [N-1:0] duty;
   logic         valid;
   logic         period_err;
   logic         stuck;

   pwm_decoder #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .step       (step),
      .pwm_in     (pwm_in),
      .duty       (duty),
      .valid      (valid),
      .period_err (period_err),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: samples since the current anchor are kept in a queue;
   // duty and period come from its contents, not from running counters.
   bit q[$];
   bit m_locked, m_static, m_prev;
   bit h1, h2;
   int m_duty, m_err, m_stuck, m_valid;
   int sample_no;

   // Observations of DUT publishes, used by the literal expectations.
   int v_count, v_duty, v_err, v_stuck, v_sample, v_cyc, v_prev_cyc;
   int v_first_duty, v_first_err, v_first_sample;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic bit gen(input int d, input int k);
      if (d >= FULL - 1) return 1'b1;
      return (k % FULL) < d;
   endfunction

   task automatic publish(input int d, input int e, input int st);
      m_valid = 1;
      m_duty  = d;
      m_err   = e;
      m_stuck = st;
   endtask

   task automatic model_clk(input bit r, input bit e, input bit st, input bit p);
      bit s;
      bit rise;
      bit fall;
      int hi;
`ifdef PWM_DECODER_SYNC_EN
      s = h2;
`else
      s = p;
`endif
      m_valid = 0;
      if (!r) begin
         q.delete();
         m_locked = 0; m_static = 0; m_prev = 0;
         h1 = 0; h2 = 0;
         m_duty = 0; m_err = 0; m_stuck = 0;
         sample_no = 0;
         return;
      end
      h2 = h1;
      h1 = p;
      if (!e) begin
         m_locked = 0; m_static = 0; m_prev = 0;
         q.delete();
         return;
      end
      if (!st) return;
      sample_no++;
      rise   = s && !m_prev;
      fall   = !s && m_prev;
      m_prev = s;
      if (m_static) begin
         if (rise) begin
            m_static = 0; m_locked = 1;
            q.delete(); q.push_back(1'b1);
         end else if (fall) begin
            m_static = 0; m_locked = 0;
            q.delete();
         end
      end else if (rise) begin
         if (m_locked) begin
            hi = 0;
            foreach (q[i]) hi += int'(q[i]);
            publish((hi > FULL - 1) ? FULL - 1 : hi, (q.size() != FULL) ? 1 : 0, 0);
         end
         m_locked = 1;
         q.delete(); q.push_back(1'b1);
      end else begin
         q.push_back(s);
         if (q.size() == TIMEOUT - 1) begin
            publish(s ? FULL - 1 : 0, 0, 1);
            m_static = 1;
         end
      end
   endtask

   task automatic compare();
      check("duty", int'(duty), m_duty);
      check("valid", int'(valid), m_valid);
      check("period_err", int'(period_err), m_err);
      check("stuck", int'(stuck), m_stuck);
      if (valid === 1'b1) begin
         v_count++;
         v_duty     = int'(duty);
         v_err      = int'(period_err);
         v_stuck    = int'(stuck);
         v_sample   = sample_no;
         v_prev_cyc = v_cyc;
         v_cyc      = cyc;
         if (v_count == 1) begin
            v_first_duty   = v_duty;
            v_first_err    = v_err;
            v_first_sample = v_sample;
         end
      end
   endtask

   task automatic tick(input bit r, input bit e, input bit st, input bit p);
      rst = r; ena = e; step = st; pwm_in = p;
      @(posedge clk);
      cyc++;
      model_clk(r, e, st, p);
      @(negedge clk);
      compare();
   endtask

   task automatic clear_v();
      v_count = 0; v_duty = -1; v_err = -1; v_stuck = -1; v_sample = -1;
      v_cyc = 0; v_prev_cyc = 0;
      v_first_duty = -1; v_first_err = -1; v_first_sample = -1;
   endtask

   task automatic reset_dut();
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      clear_v();
   endtask

   initial begin
      // Reset state
      reset_dut();
      check("rst_duty", int'(duty), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_err", int'(period_err), 0);
      check("rst_stuck", int'(stuck), 0);

      // Loopback, duty 64, one step every 4 clk
      for (int k = 0; k < 3 * FULL + 10; k++) begin
         tick(1'b1, 1'b1, 1'b1, gen(64, k));
         for (int g = 0; g < 3; g++) tick(1'b1, 1'b1, 1'b0, gen(64, k));
      end
      check("loop_count", v_count, 3);
      check("loop_duty", v_duty, 64);
      check("loop_err", v_err, 0);
      check("loop_stuck", v_stuck, 0);
      check("loop_interval", v_cyc - v_prev_cyc, 1024);
      check("model_loop_duty", m_duty, 64);

      // Duty 0 -> static low, then duty 10
      reset_dut();
      for (int k = 0; k < 600; k++) tick(1'b1, 1'b1, 1'b1, 1'b0);
      check("low_count", v_count, 1);
      check("low_duty", v_duty, 0);
      check("low_stuck", v_stuck, 1);
      check("low_sample", v_sample, 511);
      clear_v();
      for (int k = 0; k < 3 * FULL; k++) tick(1'b1, 1'b1, 1'b1, gen(10, k));
      check("d10_count", v_count, 2);
      check("d10_duty", v_duty, 10);
      check("d10_err", v_err, 0);
      check("d10_stuck", v_stuck, 0);

      // Line held high -> static all-ones, no further publishes
      reset_dut();
      for (int k = 0; k < 600; k++) tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("high_count", v_count, 1);
      check("high_duty", v_duty, 255);
      check("high_stuck", v_stuck, 1);
      check("model_high_stuck", m_stuck, 1);
      clear_v();
      for (int k = 0; k < 1000; k++) tick(1'b1, 1'b1, 1'b1, 1'b1);
      check("high_hold_count", v_count, 0);

      // Off-nominal periods: 200/50 then 300/290 (saturates)
      reset_dut();
      for (int k = 0; k < 4 * 200; k++) tick(1'b1, 1'b1, 1'b1, (k % 200) < 50);
      check("p200_duty", v_duty, 50);
      check("p200_err", v_err, 1);
      check("p200_stuck", v_stuck, 0);
      check("model_p200_duty", m_duty, 50);
      for (int k = 0; k < 3 * 300; k++) tick(1'b1, 1'b1, 1'b1, (k % 300) < 290);
      check("p300_duty", v_duty, 255);
      check("p300_err", v_err, 1);

      // Reset mid-period at duty 128
      reset_dut();
      for (int k = 0; k < 612; k++) tick(1'b1, 1'b1, 1'b1, gen(128, k));
      check("d128_duty", v_duty, 128);
      tick(1'b0, 1'b1, 1'b0, gen(128, 612));
      check("midrst_duty", int'(duty), 0);
      check("midrst_valid", int'(valid), 0);
      check("midrst_err", int'(period_err), 0);
      check("midrst_stuck", int'(stuck), 0);
      clear_v();
      for (int k = 612; k < 1212; k++) tick(1'b1, 1'b1, 1'b1, gen(128, k));
      check("midrst_first_sample", v_first_sample, 157 + SYNC_LAT);
      check("midrst_first_duty", v_first_duty, 28);
      check("midrst_first_err", v_first_err, 1);
      check("midrst_last_duty", v_duty, 128);

      // ena low mid-period: outputs hold, no valid
      tick(1'b1, 1'b0, 1'b1, gen(128, 1212));
      check("ena_duty", int'(duty), 128);
      check("ena_valid", int'(valid), 0);
      check("ena_stuck", int'(stuck), 0);
      for (int k = 1213; k < 1900; k++) tick(1'b1, 1'b1, 1'b1, gen(128, k));

      // step held low: everything frozen, valid 0
      for (int k = 0; k < 200; k++) tick(1'b1, 1'b1, 1'b0, bit'($urandom_range(0, 1)));

      // Randomized waveforms, step gaps, ena drops and resets
      for (int seg = 0; seg < 24; seg++) begin
         int per;
         int hi;
         int reps;
         per  = $urandom_range(1, 400);
         hi   = $urandom_range(0, per);
         reps = $urandom_range(1, 2);
         if ($urandom_range(0, 15) == 0) tick(1'b0, 1'b1, 1'b0, 1'b0);
         for (int k = 0; k < reps * per; k++) begin
            bit p;
            p = (k % per) < hi;
            if ($urandom_range(0, 63) == 0) tick(1'b1, 1'b0, bit'($urandom_range(0, 1)), p);
            tick(1'b1, 1'b1, 1'b1, p);
            if ($urandom_range(0, 2) == 0) tick(1'b1, 1'b1, 1'b0, p);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
